tbu_frame: RTL and testbench

- Traceback / survivor-memory unit directly downstream of the path metric unit (pmu) in the Viterbi decoder.
- Each valid cycle it consumes one trellis column from pmu: the per-state survivor word and the per-state path metrics.
- It stores columns in a ping-pong survivor buffer. When a frame closes, it starts at the minimum-metric state and traces back one column per cycle, then emits the decoded frame as a parallel word.

---
 rtl/tbu_frame_if.sv | 27 ++
 rtl/tbu_frame.sv | 156 +++++++++++++++
 tb/tb_tbu_frame.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/tbu_frame_if.sv
// rtl/tbu_frame_if.sv - Column input stream and decoded-frame output bundle for tbu_frame.
interface tbu_frame_if #(
  parameter int K  = 3,
  parameter int TB = 16,
  parameter int LW = $clog2(TB + 1)
);
  localparam int NS = 1 << (K - 1);

  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [NS*K-1:0]   path_in;
  logic [NS*8-1:0]   dis_in;
  logic              out_valid;
  logic [TB-1:0]     out_bits;
  logic [LW-1:0]     out_len;

  modport slave (
    input  in_valid, in_last, path_in, dis_in,
    output in_ready, out_valid, out_bits, out_len
  );

  modport master (
    output in_valid, in_last, path_in, dis_in,
    input  in_ready, out_valid, out_bits, out_len
  );
endinterface

// File: rtl/tbu_frame.sv
// rtl/tbu_frame.sv - Viterbi traceback unit with ping-pong survivor banks.
module tbu_frame #(
  parameter int K  = 3,
  parameter int TB = 16,
  parameter int LW = $clog2(TB + 1)
) (
  input  logic        clk,
  input  logic        rst,
  tbu_frame_if.slave  io_bus
);
  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int PW = NS * K;
  localparam int IW = (TB > 1) ? $clog2(TB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_TRACE, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_start;
  logic          w_finish;

  logic [PW-1:0] r_mem [2][TB];
  logic          r_wb;
  logic [IW-1:0] r_widx;
  logic [1:0]    r_full;
  logic [LW-1:0] r_len [2];
  logic [SW-1:0] r_start [2];

  logic          r_tb_bank;
  logic          r_tb_next;
  logic [SW-1:0] r_cur;
  logic [IW-1:0] r_idx;
  logic [TB-1:0] r_acc;

  logic          r_out_valid;
  logic [TB-1:0] r_out_bits;
  logic [LW-1:0] r_out_len;

  logic          w_accept;
  logic          w_close;
  logic [SW-1:0] w_min_state;
  logic [7:0]    w_min_val;
  logic [PW-1:0] w_col;
  logic [K-1:0]  w_word;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;

  assign w_accept = io_bus.in_valid & ~r_full[r_wb];
  assign w_close  = w_accept & (io_bus.in_last | (r_widx == IW'(TB - 1)));

  // Strict less-than keeps the lowest state index on metric ties.
  always_comb begin
    w_min_state = '0;
    w_min_val   = io_bus.dis_in[7:0];
    for (int s = 1; s < NS; s++) begin
      if (io_bus.dis_in[8*s +: 8] < w_min_val) begin
        w_min_val   = io_bus.dis_in[8*s +: 8];
        w_min_state = SW'(s);
      end
    end
  end

  assign w_col  = r_mem[r_tb_bank][r_idx];
  assign w_word = w_col[K*r_cur +: K];

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_full[r_tb_next]) begin
          w_next  = S_TRACE;
          w_start = 1'b1;
        end
      end
      S_TRACE: begin
        if (r_idx == '0) w_next = S_DONE;
      end
      S_DONE: begin
        w_next   = S_IDLE;
        w_finish = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Set and clear always target different banks, so both land in one cycle.
  assign w_full_set = w_close  ? (2'b01 << r_wb)      : 2'b00;
  assign w_full_clr = w_finish ? (2'b01 << r_tb_bank) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_accept) r_mem[r_wb][r_widx] <= io_bus.path_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb        <= 1'b0;
      r_widx      <= '0;
      r_full      <= 2'b00;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_start[0]  <= '0;
      r_start[1]  <= '0;
      r_tb_bank   <= 1'b0;
      r_tb_next   <= 1'b0;
      r_cur       <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_out_len   <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_full      <= (r_full | w_full_set) & ~w_full_clr;
      if (w_accept) begin
        if (w_close) begin
          r_len[r_wb]   <= LW'(r_widx) + LW'(1);
          r_start[r_wb] <= w_min_state;
          r_wb          <= ~r_wb;
          r_widx        <= '0;
        end else begin
          r_widx <= r_widx + IW'(1);
        end
      end
      if (w_start) begin
        r_tb_bank <= r_tb_next;
        r_tb_next <= ~r_tb_next;
        r_cur     <= r_start[r_tb_next];
        r_idx     <= IW'(r_len[r_tb_next] - LW'(1));
        r_acc     <= '0;
      end
      if (r_state == S_TRACE) begin
        r_acc[r_idx] <= w_word[K-1];
        r_cur        <= w_word[K-2:0];
        if (r_idx != '0) r_idx <= r_idx - IW'(1);
      end
      if (w_finish) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= r_acc;
        r_out_len   <= r_len[r_tb_bank];
      end
    end
  end

  assign io_bus.in_ready  = ~r_full[r_wb];
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_bits  = r_out_bits;
  assign io_bus.out_len   = r_out_len;
endmodule

// File: tb/tb_tbu_frame.sv
// tb/tb_tbu_frame.sv - Scoreboard bench for tbu_frame against a traceback reference model.
module tb_tbu_frame;
  localparam int K  = 3;
  localparam int TB = 16;
  localparam int LW = $clog2(TB + 1);
  localparam int NS = 1 << (K - 1);
  localparam int PW = NS * K;
  localparam int DW = NS * 8;

  typedef struct {
    logic [TB-1:0] bits;
    int            len;
    int            tclose;
    bit            chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   lat_chk = 1'b0;
  bit   no_push = 1'b0;

  exp_t          sb[$];
  exp_t          m_e;
  logic [PW-1:0] mcols[$];

  tbu_frame_if #(.K(K), .TB(TB), .LW(LW)) io();

  tbu_frame #(.K(K), .TB(TB), .LW(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: argmin of the closing metrics, then follow predecessors oldest-ward.
  function automatic void model_close(input logic [DW-1:0] d, input int tc);
    exp_t         e;
    int           st;
    int           best;
    int           n;
    logic [K-1:0] w;
    logic [PW-1:0] col;
    best = 256;
    st   = 0;
    for (int s = 0; s < NS; s++) begin
      if (int'(d[8*s +: 8]) < best) begin
        best = int'(d[8*s +: 8]);
        st   = s;
      end
    end
    n      = mcols.size();
    e.bits = '0;
    for (int c = n - 1; c >= 0; c--) begin
      col       = mcols[c];
      w         = col[K*st +: K];
      e.bits[c] = w[K-1];
      st        = int'(w[K-2:0]);
    end
    e.len    = n;
    e.tclose = tc;
    e.chk    = lat_chk;
    if (!no_push) sb.push_back(e);
    mcols.delete();
  endfunction

  function automatic logic [DW-1:0] rand_dis();
    logic [DW-1:0] d;
    logic [7:0]    tie;
    tie = 8'($urandom_range(0, 255));
    for (int s = 0; s < NS; s++) begin
      d[8*s +: 8] = ($urandom_range(0, 3) == 0) ? tie : 8'($urandom_range(0, 255));
    end
    return d;
  endfunction

  task automatic send(input logic [PW-1:0] p, input logic [DW-1:0] d, input bit last);
    int g;
    g = 0;
    io.in_valid = 1'b1;
    io.path_in  = p;
    io.dis_in   = d;
    io.in_last  = last;
    @(negedge clk);
    while (io.in_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready=0 expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    mcols.push_back(p);
    if (last || mcols.size() == TB) model_close(d, cyc);
  endtask

  task automatic idle_cycle();
    io.in_valid = 1'b0;
    io.in_last  = 1'($urandom_range(0, 1));
    io.path_in  = PW'($urandom);
    io.dis_in   = rand_dis();
    @(posedge clk);
    #1;
    io.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(posedge clk);
      g++;
    end
    if (g >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames pending expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_const(input logic [PW-1:0] p, input logic [DW-1:0] d, input int n, input bit use_last);
    for (int i = 0; i < n; i++) send(p, d, use_last && (i == n - 1));
  endtask

  task automatic send_random_frame(input int maxlen);
    int n;
    n = $urandom_range(1, maxlen);
    for (int i = 0; i < n; i++) send(PW'($urandom), rand_dis(), i == n - 1);
  endtask

  always @(negedge clk) begin
    if (io.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with out_len=%0d expected no pending frame", io.out_len);
      end else begin
        m_e = sb.pop_front();
        check("out_bits", longint'(io.out_bits), longint'(m_e.bits));
        check("out_len", longint'(io.out_len), longint'(m_e.len));
        if (m_e.chk) check("latency", longint'(cyc - m_e.tclose), longint'(m_e.len + 2));
      end
    end
  end

  initial begin
    io.in_valid = 1'b0;
    io.in_last  = 1'b0;
    io.path_in  = '0;
    io.dis_in   = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", longint'(io.out_valid), 0);
    check("reset_out_bits", longint'(io.out_bits), 0);
    check("reset_out_len", longint'(io.out_len), 0);
    check("reset_in_ready", longint'(io.in_ready), 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send_const('0, {8'd5, 8'd5, 8'd5, 8'd0}, TB, 1'b0);
    wait_drain();
    send_const({3'b000, 3'b101, 3'b010, 3'b000}, {8'd9, 8'd1, 8'd9, 8'd9}, TB, 1'b0);
    wait_drain();
    send_const({3'b000, 3'b000, 3'b000, 3'b100}, {8'd7, 8'd7, 8'd7, 8'd7}, TB, 1'b0);
    wait_drain();
    send_const({3'b000, 3'b101, 3'b010, 3'b000}, {8'd9, 8'd1, 8'd9, 8'd9}, 5, 1'b1);
    wait_drain();

    lat_chk = 1'b0;
    for (int i = 0; i < TB; i++) send(PW'($urandom), rand_dis(), 1'b0);
    send(PW'($urandom), rand_dis(), 1'b1);
    @(negedge clk);
    check("backpressure_in_ready", longint'(io.in_ready), 0);
    @(posedge clk);
    #1;
    for (int f = 0; f < 4; f++) send_random_frame(TB);
    wait_drain();

    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, TB);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send(PW'($urandom), rand_dis(), (i == n - 1) && (n < TB));
      end
    end
    wait_drain();

    no_push = 1'b1;
    for (int i = 0; i < TB; i++) send(PW'($urandom), {8'd3, 8'd2, 8'd1, 8'd0}, 1'b0);
    no_push = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", longint'(io.out_valid), 0);
    check("midreset_out_bits", longint'(io.out_bits), 0);
    check("midreset_out_len", longint'(io.out_len), 0);
    check("midreset_in_ready", longint'(io.in_ready), 1);
    repeat (40) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    for (int i = 0; i < TB; i++) send(PW'($urandom), rand_dis(), 1'b0);
    wait_drain();

    check("scoreboard_empty", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
